pipeline_ctrl: RTL

Central pipeline sequencer for the RV32IM five-stage core. It turns the hazard unit's load-use stall, EX-stage branch redirects, multi-cycle divide/remainder operations and data-memory wait states into per-stage register enables and flush (bubble) controls. It owns the start/done handshake with the iterative divider and keeps saturating performance counters for stall and flush cycles. It sits in the ID stage alongside the hazard unit and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipeline_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the five-stage core: turns stall, redirect, divide and
// data-memory wait conditions into per-stage enables/flushes, plus perf counters.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             ex_div_op,
    input  logic             div_done,
    input  logic             dmem_busy,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             div_start,
    output logic             div_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {RUN, DIV_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        div_start    = 1'b0;
        state_d      = state_q;
        done_d       = done_q;

        if (reset) begin
            state_d = RUN;
            done_d  = 1'b0;
        end else if (dmem_busy) begin
            // Whole pipe frozen; remember a done pulse so the divide can retire later.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            if (state_q == DIV_WAIT && div_done) done_d = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_div_op) begin
                        div_start    = 1'b1;
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_d      = DIV_WAIT;
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (div_done || done_q) begin
                        state_d = RUN;
                        done_d  = 1'b0;
                    end else begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign div_busy = !reset && (state_q == DIV_WAIT);

    // Clear wins over increment; both counters stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_en && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
            if (if_id_flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            done_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
